neo_memcard_resp: RTL and testbench

- Simulation model of the memory card itself: the responder at the far end of the card bus that the E0 glue drives through CDA and the card strobes.
- Holds an 8-bit SRAM array and answers reads after a fixed access delay.
- Commits writes at the end of each write pulse and honours the write-protect switch.
- Reports card-detect and write-protect status back to the console side.

---
 rtl/neo_memcard_resp_if.sv | 30 +++
 rtl/neo_memcard_resp.sv | 183 ++++++++++++++++++
 tb/tb_neo_memcard_resp.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/neo_memcard_resp_if.sv
// Card bus between the console-side glue and the memory card responder.
// Purely combinational bundle; no latency of its own.
// No backpressure: the card answers strobes at its own fixed pace.
interface neo_memcard_resp_if;
  logic [23:0] CDA;
  logic        nCRDC;
  logic        nCRDO;
  logic        nCRDW;
  logic [7:0]  CDD_IN;
  logic [7:0]  CDD_OUT;
  logic        CDD_OE;
  logic        CARD_PRESENT;
  logic        WP_SW;
  logic        nCD1;
  logic        nCD2;
  logic        WP;
  logic [15:0] WR_COUNT;

  // Console side: drives address, strobes, write data and the bench switches.
  modport master (
    output CDA, nCRDC, nCRDO, nCRDW, CDD_IN, CARD_PRESENT, WP_SW,
    input  CDD_OUT, CDD_OE, nCD1, nCD2, WP, WR_COUNT
  );

  // Card side: answers reads, reports detect / protect status.
  modport slave (
    input  CDA, nCRDC, nCRDO, nCRDW, CDD_IN, CARD_PRESENT, WP_SW,
    output CDD_OUT, CDD_OE, nCD1, nCD2, WP, WR_COUNT
  );
endinterface

// File: rtl/neo_memcard_resp.sv
// Memory card responder model: byte SRAM with registered strobe sampling.
// Read data drives ACCESS_CYC+1 edges after strobes are first sampled low.
// No backpressure: writes commit on the trailing edge of the write pulse.
module neo_memcard_resp #(
  parameter int ADDR_W     = 11,
  parameter int ACCESS_CYC = 3
) (
  input logic              CLK_24M,
  input logic              RESET,
  neo_memcard_resp_if.slave card
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYC - 1);

  state_t            r_state;
  state_t            w_nxt_state;

  // Registered copies of the card pins; the FSM only ever looks at these.
  logic              r_ce_s;
  logic              r_oe_s;
  logic              r_we_s;
  logic [ADDR_W-1:0] r_addr_s;
  logic [7:0]        r_din_s;

  logic [ADDR_W-1:0] r_rd_addr;
  logic [3:0]        r_cnt;
  logic [7:0]        r_dout;
  logic              r_oe;

  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_dat;
  logic [15:0]       r_wr_count;

  logic              r_ncd;
  logic              r_wp;

  logic [7:0]        r_mem [0:(1 << ADDR_W) - 1];

  logic              w_rd_load;
  logic              w_cnt_dec;
  logic              w_drive;
  logic              w_wr_latch;
  logic              w_commit;
  logic              w_rd_abort;

  assign w_rd_abort = r_ce_s | r_oe_s;

  // Sample strobes, low address bits and write data every edge.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      r_ce_s   <= 1'b1;
      r_oe_s   <= 1'b1;
      r_we_s   <= 1'b1;
      r_addr_s <= '0;
      r_din_s  <= '0;
    end else begin
      r_ce_s   <= card.nCRDC;
      r_oe_s   <= card.nCRDO;
      r_we_s   <= card.nCRDW;
      r_addr_s <= card.CDA[ADDR_W-1:0];
      r_din_s  <= card.CDD_IN;
    end
  end

  // Card-detect and write-protect status, one cycle behind the switches.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      r_ncd <= 1'b1;
      r_wp  <= 1'b0;
    end else begin
      r_ncd <= ~card.CARD_PRESENT;
      r_wp  <= card.WP_SW & card.CARD_PRESENT;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK_24M) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_nxt_state;
  end

  // Next state and per-cycle datapath controls; removal overrides everything.
  always_comb begin
    w_nxt_state = r_state;
    w_rd_load   = 1'b0;
    w_cnt_dec   = 1'b0;
    w_drive     = 1'b0;
    w_wr_latch  = 1'b0;
    w_commit    = 1'b0;
    if (!card.CARD_PRESENT) begin
      w_nxt_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          // Write wins when OE and WE are both low.
          if (!r_ce_s && !r_we_s) begin
            w_nxt_state = WR_ACTIVE;
            w_wr_latch  = 1'b1;
          end else if (!r_ce_s && !r_oe_s) begin
            w_nxt_state = RD_WAIT;
            w_rd_load   = 1'b1;
          end
        end
        RD_WAIT: begin
          if (w_rd_abort) begin
            w_nxt_state = IDLE;
          end else if (r_cnt == 4'd0) begin
            w_nxt_state = RD_DRIVE;
            w_drive     = 1'b1;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        RD_DRIVE: begin
          if (w_rd_abort) begin
            w_nxt_state = IDLE;
          end else if (r_addr_s != r_rd_addr) begin
            w_nxt_state = RD_WAIT;
            w_rd_load   = 1'b1;
          end
        end
        WR_ACTIVE: begin
          if (!r_we_s && !r_ce_s) begin
            w_wr_latch = 1'b1;
          end else begin
            w_nxt_state = IDLE;
            w_commit    = ~card.WP_SW;
          end
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  // Read path: address latch, access-delay counter and output drive.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      r_rd_addr <= '0;
      r_cnt     <= '0;
      r_dout    <= '0;
      r_oe      <= 1'b0;
    end else begin
      r_oe <= (w_nxt_state == RD_DRIVE);
      if (w_rd_load) begin
        r_rd_addr <= r_addr_s;
        r_cnt     <= CNT_LOAD;
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_drive) r_dout <= r_mem[r_rd_addr];
    end
  end

  // Write path: track address/data through the pulse, count real commits.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      r_wr_addr  <= '0;
      r_wr_dat   <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_wr_latch) begin
        r_wr_addr <= r_addr_s;
        r_wr_dat  <= r_din_s;
      end
      if (w_commit && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 16'd1;
    end
  end

  // Array write port; contents survive reset and card removal.
  always_ff @(posedge CLK_24M) begin
    if (w_commit && !RESET) r_mem[r_wr_addr] <= r_wr_dat;
  end

  assign card.CDD_OUT  = r_dout;
  assign card.CDD_OE   = r_oe;
  assign card.nCD1     = r_ncd;
  assign card.nCD2     = r_ncd;
  assign card.WP       = r_wp;
  assign card.WR_COUNT = r_wr_count;

endmodule

// File: tb/tb_neo_memcard_resp.sv
// Directed bench for the memory card responder.
// Inputs change and outputs are sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_neo_memcard_resp;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic oe_seen;

  neo_memcard_resp_if bus();

  neo_memcard_resp #(.ADDR_W(11), .ACCESS_CYC(3)) dut (
    .CLK_24M (clk),
    .RESET   (rst),
    .card    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sticky flag: any cycle on which the card drives the bus.
  always @(negedge clk) if (bus.CDD_OE === 1'b1) oe_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobes_off();
    bus.nCRDC = 1'b1;
    bus.nCRDO = 1'b1;
    bus.nCRDW = 1'b1;
  endtask

  task automatic wr(input logic [23:0] a, input logic [7:0] d, input int nlow, input logic oe_low);
    @(negedge clk);
    bus.CDA    = a;
    bus.CDD_IN = d;
    bus.nCRDC  = 1'b0;
    bus.nCRDW  = 1'b0;
    bus.nCRDO  = ~oe_low;
    repeat (nlow) @(negedge clk);
    strobes_off();
    repeat (3) @(negedge clk);
  endtask

  // Returns the number of edges from the first low sample to CDD_OE, or -1.
  task automatic rd(input logic [23:0] a, output logic [7:0] d, output int lat);
    @(negedge clk);
    bus.CDA   = a;
    bus.nCRDC = 1'b0;
    bus.nCRDO = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.CDD_OE === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
    d = bus.CDD_OUT;
    strobes_off();
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_oe(output int ok);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.CDD_OE === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    int         lat;
    int         ok;
    n_checks = 0;
    n_errors = 0;
    oe_seen  = 1'b0;
    rst = 1'b1;
    strobes_off();
    bus.CDA          = '0;
    bus.CDD_IN       = '0;
    bus.CARD_PRESENT = 1'b1;
    bus.WP_SW        = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values hold even with the card inserted.
    check("rst_oe",    32'(bus.CDD_OE),   32'h0);
    check("rst_out",   32'(bus.CDD_OUT),  32'h0);
    check("rst_ncd1",  32'(bus.nCD1),     32'h1);
    check("rst_ncd2",  32'(bus.nCD2),     32'h1);
    check("rst_wp",    32'(bus.WP),       32'h0);
    check("rst_count", 32'(bus.WR_COUNT), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ncd1_in", 32'(bus.nCD1), 32'h0);
    check("ncd2_in", 32'(bus.nCD2), 32'h0);

    // Write then read back with the access latency.
    wr(24'h000010, 8'hA5, 4, 1'b0);
    check("wr_count1", 32'(bus.WR_COUNT), 32'd1);
    rd(24'h000010, d, lat);
    check("rd_a5",  32'(d),   32'hA5);
    check("rd_lat", 32'(lat), 32'd4);

    // Address mirroring on the low 11 bits.
    wr(24'h000805, 8'h3C, 2, 1'b0);
    check("wr_count2", 32'(bus.WR_COUNT), 32'd2);
    rd(24'h000005, d, lat);
    check("mirror_lo", 32'(d), 32'h3C);
    rd(24'hBFF805, d, lat);
    check("mirror_hi",     32'(d),   32'h3C);
    check("mirror_hi_lat", 32'(lat), 32'd4);

    // Write protect.
    @(negedge clk);
    bus.WP_SW = 1'b1;
    check("wp_before", 32'(bus.WP), 32'h0);
    @(negedge clk);
    check("wp_after", 32'(bus.WP), 32'h1);
    wr(24'h000010, 8'hFF, 3, 1'b0);
    check("wp_count", 32'(bus.WR_COUNT), 32'd2);
    bus.WP_SW = 1'b0;
    rd(24'h000010, d, lat);
    check("wp_data", 32'(d),      32'hA5);
    check("wp_off",  32'(bus.WP), 32'h0);

    // Read abort: OE released during the access delay.
    @(negedge clk);
    oe_seen   = 1'b0;
    bus.CDA   = 24'h000010;
    bus.nCRDC = 1'b0;
    bus.nCRDO = 1'b0;
    repeat (2) @(negedge clk);
    bus.nCRDO = 1'b1;
    repeat (10) @(negedge clk);
    strobes_off();
    repeat (2) @(negedge clk);
    check("abort_no_oe", 32'(oe_seen), 32'h0);

    // OE and WE together: write wins, card stays off the bus.
    oe_seen = 1'b0;
    wr(24'h000020, 8'h5A, 3, 1'b1);
    check("prio_no_oe", 32'(oe_seen),      32'h0);
    check("prio_count", 32'(bus.WR_COUNT), 32'd3);
    rd(24'h000020, d, lat);
    check("prio_data", 32'(d), 32'h5A);

    // Address change while driving re-runs the access.
    @(negedge clk);
    bus.CDA   = 24'h000010;
    bus.nCRDC = 1'b0;
    bus.nCRDO = 1'b0;
    wait_oe(ok);
    check("chg_first_ok", 32'(ok),          32'h1);
    check("chg_first",    32'(bus.CDD_OUT), 32'hA5);
    bus.CDA = 24'h000020;
    repeat (2) @(negedge clk);
    check("chg_oe_drop", 32'(bus.CDD_OE), 32'h0);
    wait_oe(ok);
    check("chg_second_ok", 32'(ok),          32'h1);
    check("chg_second",    32'(bus.CDD_OUT), 32'h5A);
    strobes_off();
    repeat (3) @(negedge clk);

    // Card removal mid-write discards the write.
    wr(24'h000030, 8'h11, 2, 1'b0);
    check("pre_rm_count", 32'(bus.WR_COUNT), 32'd4);
    @(negedge clk);
    bus.CDA    = 24'h000030;
    bus.CDD_IN = 8'h77;
    bus.nCRDC  = 1'b0;
    bus.nCRDW  = 1'b0;
    repeat (3) @(negedge clk);
    bus.CARD_PRESENT = 1'b0;
    @(negedge clk);
    check("rm_ncd1", 32'(bus.nCD1),   32'h1);
    check("rm_ncd2", 32'(bus.nCD2),   32'h1);
    check("rm_oe",   32'(bus.CDD_OE), 32'h0);
    strobes_off();
    repeat (3) @(negedge clk);

    // No card: read strobes never drive the bus.
    oe_seen   = 1'b0;
    bus.CDA   = 24'h000010;
    bus.nCRDC = 1'b0;
    bus.nCRDO = 1'b0;
    repeat (10) @(negedge clk);
    strobes_off();
    @(negedge clk);
    check("nocard_no_oe", 32'(oe_seen), 32'h0);
    bus.CARD_PRESENT = 1'b1;
    repeat (2) @(negedge clk);
    check("rm_count", 32'(bus.WR_COUNT), 32'd4);
    rd(24'h000030, d, lat);
    check("rm_data", 32'(d), 32'h11);

    // Reset while driving read data.
    @(negedge clk);
    bus.CDA   = 24'h000010;
    bus.nCRDC = 1'b0;
    bus.nCRDO = 1'b0;
    wait_oe(ok);
    check("rstdrv_ok", 32'(ok), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rstdrv_oe",    32'(bus.CDD_OE),   32'h0);
    check("rstdrv_out",   32'(bus.CDD_OUT),  32'h0);
    check("rstdrv_count", 32'(bus.WR_COUNT), 32'h0);
    rst = 1'b0;
    strobes_off();
    repeat (3) @(negedge clk);
    rd(24'h000010, d, lat);
    check("post_rst_a5", 32'(d), 32'hA5);
    rd(24'h000005, d, lat);
    check("post_rst_3c", 32'(d), 32'h3C);

    // Saturation: preload the counter near the top, then commit three writes.
    @(negedge clk);
    force dut.r_wr_count = 16'hFFFD;
    #1;
    release dut.r_wr_count;
    wr(24'h000040, 8'h01, 1, 1'b0);
    check("sat_fffe", 32'(bus.WR_COUNT), 32'hFFFE);
    wr(24'h000040, 8'h02, 1, 1'b0);
    check("sat_ffff", 32'(bus.WR_COUNT), 32'hFFFF);
    wr(24'h000040, 8'h03, 1, 1'b0);
    check("sat_hold", 32'(bus.WR_COUNT), 32'hFFFF);
    rd(24'h000040, d, lat);
    check("sat_data", 32'(d), 32'h03);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
